// File: rtl/shift_add_multiplier.sv
// Sequential unsigned WIDTH x WIDTH shift-and-add multiplier controller.
// The adder is external: this block presents its operands from registers
// and folds the returned sum/carry back into the accumulator.
module shift_add_multiplier #(
  parameter int WIDTH = 4
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic [WIDTH-1:0]   i_multiplicand,
  input  logic [WIDTH-1:0]   i_multiplier,
  output logic               o_busy,
  output logic               o_done,
  output logic [2*WIDTH-1:0] o_product,
  output logic [WIDTH-1:0]   o_add_a,
  output logic [WIDTH-1:0]   o_add_b,
  output logic               o_add_cin,
  input  logic [WIDTH-1:0]   i_add_sum,
  input  logic               i_add_cout
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ADD   = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic [WIDTH-1:0]     r_a;
  logic [WIDTH-1:0]     r_q;
  logic [WIDTH-1:0]     r_m;
  logic                 r_c;
  logic [CNT_W-1:0]     r_cnt;
  logic [2*WIDTH-1:0]   r_product;
  logic                 w_last_shift;

  // The final shift happens when the bit counter is about to reach zero.
  assign w_last_shift = (r_cnt == CNT_W'(1));

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode: IDLE waits for start, then ADD/SHIFT alternate WIDTH times.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (i_start) w_state_next = S_ADD;
      S_ADD:   w_state_next = S_SHIFT;
      S_SHIFT: w_state_next = w_last_shift ? S_DONE : S_ADD;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Datapath: operand capture, conditional accumulate, and the {C,A,Q} right shift.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_a       <= '0;
      r_q       <= '0;
      r_m       <= '0;
      r_c       <= 1'b0;
      r_cnt     <= '0;
      r_product <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_m   <= i_multiplicand;
            r_q   <= i_multiplier;
            r_a   <= '0;
            r_c   <= 1'b0;
            r_cnt <= CNT_W'(WIDTH);
          end
        end
        S_ADD: begin
          if (r_q[0]) begin
            r_c <= i_add_cout;
            r_a <= i_add_sum;
          end else begin
            r_c <= 1'b0;
          end
        end
        S_SHIFT: begin
          r_c   <= 1'b0;
          r_a   <= {r_c, r_a[WIDTH-1:1]};
          r_q   <= {r_a[0], r_q[WIDTH-1:1]};
          r_cnt <= r_cnt - CNT_W'(1);
          // Latch the shifted {A,Q} so the product is already valid while done is high.
          if (w_last_shift) begin
            r_product <= {r_c, r_a, r_q[WIDTH-1:1]};
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Status decoded from the registered state only, so it cannot glitch.
  assign o_busy    = (r_state != S_IDLE);
  assign o_done    = (r_state == S_DONE);
  assign o_product = r_product;

  // Adder operands come straight from registers, so there is no loop through the adder.
  assign o_add_a   = r_a;
  assign o_add_b   = r_m;
  assign o_add_cin = 1'b0;

endmodule
